// File: rtl/microwave_pkg.sv
// Shared types, constants and BCD arithmetic for the microwave cook timer.
//   bcd_t          : one BCD digit
//   timer_state_t  : IDLE / SET / COUNT / EXPIRED
//   bcd_time_t     : mm:ss as four packed BCD digits
//   bcd_add        : add 1:00 and/or 0:10 with saturation at 99:59
//   bcd_dec        : subtract one second (caller guarantees time != 00:00)
package microwave_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SET     = 2'd1,
    COUNT   = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } bcd_time_t;

  localparam logic [7:0] MAX_MIN_BCD = 8'h99;
  localparam logic [7:0] MAX_SEC_BCD = 8'h59;

  // Both pulses may apply at once. The 10 s add can carry one minute, so the
  // minute increment is 0..2; any carry out of the tens-of-minutes digit means
  // the true result exceeds 99:59 and the whole value clamps to 99:59.
  function automatic bcd_time_t bcd_add(input bcd_time_t t, input logic add_min,
                                        input logic add_10s);
    bcd_time_t  r;
    logic [1:0] inc;
    logic [4:0] ones;
    logic       sat;
    r   = t;
    inc = {1'b0, add_min};
    sat = 1'b0;
    if (add_10s) begin
      if (r.sec_tens == 4'd5) begin
        r.sec_tens = 4'd0;
        inc        = inc + 2'd1;
      end else begin
        r.sec_tens = r.sec_tens + 4'd1;
      end
    end
    ones = {1'b0, r.min_ones} + {3'b000, inc};
    if (ones > 5'd9) begin
      r.min_ones = 4'(ones - 5'd10);
      if (r.min_tens == 4'd9) begin
        sat = 1'b1;
      end else begin
        r.min_tens = r.min_tens + 4'd1;
      end
    end else begin
      r.min_ones = ones[3:0];
    end
    if (sat) begin
      r = bcd_time_t'({MAX_MIN_BCD, MAX_SEC_BCD});
    end
    return r;
  endfunction

  // One-second BCD decrement with borrows ss 00 -> 59 and mm x0 -> (x-1)9.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (r.sec_ones != 4'd0) begin
      r.sec_ones = r.sec_ones - 4'd1;
    end else begin
      r.sec_ones = 4'd9;
      if (r.sec_tens != 4'd0) begin
        r.sec_tens = r.sec_tens - 4'd1;
      end else begin
        r.sec_tens = 4'd5;
        if (r.min_ones != 4'd0) begin
          r.min_ones = r.min_ones - 4'd1;
        end else begin
          r.min_ones = 4'd9;
          r.min_tens = r.min_tens - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/microwave_prescaler.sv
// Divides the system clock down to one cooking second.
//   clk, nrst : clock and synchronous active-low reset
//   en        : advance the count this cycle (held value when low)
//   clr       : force the count to zero (wins over en)
//   sec_tick  : combinational strobe, high on the cycle the count wraps
module microwave_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic clr,
  output logic sec_tick
);

  localparam int W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] cnt;

  assign sec_tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sec_tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/microwave_timer.sv
// Cook-time countdown: holds a BCD mm:ss time loaded by front-panel pulses and
// counts it down once per second while the controller heats.
//   clk, nrst          : clock and synchronous active-low reset
//   run                : level, controller is heating
//   add_min, add_10s   : one-cycle pulses adding 1:00 / 0:10 (only while idle/set)
//   clear              : one-cycle pulse, cancel and zero the time
//   min_tens..sec_ones : registered BCD display digits
//   ready              : registered, time != 00:00
//   finish             : registered one-cycle strobe when the count reaches 00:00
// The FSM state is held in state_q.
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic run,
  input  logic add_min,
  input  logic add_10s,
  input  logic clear,
  output bcd_t min_tens,
  output bcd_t min_ones,
  output bcd_t sec_tens,
  output bcd_t sec_ones,
  output logic ready,
  output logic finish
);

  timer_state_t state_q;
  bcd_time_t    time_q;
  bcd_time_t    added;
  bcd_time_t    decd;
  logic         sec_tick;
  logic         presc_en;

  assign added = bcd_add(time_q, add_min, add_10s);
  assign decd  = bcd_dec(time_q);

  // The prescaler only advances while actually counting; it keeps its value
  // through a pause so a partial second survives a door opening.
  assign presc_en = (state_q == COUNT) && run;

  microwave_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_presc (
    .clk      (clk),
    .nrst     (nrst),
    .en       (presc_en),
    .clr      (clear),
    .sec_tick (sec_tick)
  );

  assign min_tens = time_q.min_tens;
  assign min_ones = time_q.min_ones;
  assign sec_tens = time_q.sec_tens;
  assign sec_ones = time_q.sec_ones;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      time_q  <= '0;
      ready   <= 1'b0;
      finish  <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      time_q  <= '0;
      ready   <= 1'b0;
      finish  <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state_q)
        IDLE, SET: begin
          if (state_q == SET && run) begin
            state_q <= COUNT;
          end else if (!run) begin
            // State follows the freshly loaded time on the same edge.
            time_q  <= added;
            ready   <= (added != '0);
            state_q <= (added != '0) ? SET : IDLE;
          end
        end
        COUNT: begin
          if (!run) begin
            state_q <= SET;
          end else if (sec_tick) begin
            time_q <= decd;
            if (decd == '0) begin
              finish  <= 1'b1;
              ready   <= 1'b0;
              state_q <= EXPIRED;
            end
          end
        end
        EXPIRED: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/microwave_timer.md
# microwave_timer

Cook-time countdown feeding the microwave door/heat controller. Holds a BCD mm:ss cook time set by front-panel buttons and counts it down one second at a time while the controller reports heating. On reaching 00:00 it emits the single-cycle `finish` strobe the controller consumes. It also drives the four-digit display and a `ready` flag used to gate `start`.

## Interface
- TICKS_PER_SEC, default 50_000_000: clock cycles per cooking second; minimum 2.
- clk  in  1  system clock; all logic on rising edge.
- nrst  in  1  synchronous, active-low reset.
- run  in  1  level; high while the controller is heating; connect to the controller's `heat`.
- add_min  in  1  one-cycle pulse; add 1:00.
- add_10s  in  1  one-cycle pulse; add 0:10.
- clear  in  1  one-cycle pulse; cancel and zero the time.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits; registered.
- ready  out  1  time ≠ 00:00; registered.
- finish  out  1  one-cycle pulse on expiry; registered.

## Operation
- Reset with nrst low at a rising edge: all digits 0, prescaler 0, state IDLE, ready 0, finish 0. This applies mid-count; no finish is emitted.
- States:
  - IDLE: time 00:00.
  - SET: time nonzero and run low.
  - COUNT: time nonzero and run high.
  - EXPIRED: lasts exactly one cycle.
- Priority per cycle: nrst, then clear, then decrement or adds.
- clear, in any state: time → 00:00, prescaler → 0, next state IDLE, finish stays 0.
- Adds are honoured only when run = 0, in IDLE or SET. They are ignored in COUNT and EXPIRED.
- add_min and add_10s in the same cycle both apply: +1:10.
- Add arithmetic is BCD:
  - sec_tens increments; 6 wraps to 0 and carries into minutes.
  - minutes form a 2-digit BCD value.
  - A result above 99:59 saturates to 99:59.
- IDLE/SET: the state tracks the time value. A nonzero time → SET, zero → IDLE. Entering SET from IDLE takes effect on the same edge that loads the time.
- SET → COUNT when run = 1. COUNT → SET when run = 0.
- Pausing holds the prescaler value, so the partial second is preserved. Resuming continues from the held value.
- run = 1 in IDLE has no effect: no count, no finish. Integration gates the controller's `start` with `ready`.
- COUNT behaviour:
  - The prescaler increments each cycle.
  - When prescaler = TICKS_PER_SEC−1 it wraps to 0 and the time decrements by one second.
  - BCD decrement: ss 00 → 59 with a borrow from mm.
- Expiry: when a decrement takes the time to 00:00, on the same edge finish → 1, state → EXPIRED, prescaler → 0.
- EXPIRED → IDLE on the next edge, with finish → 0. Adds are ignored during EXPIRED.
- Illegal digit values (>9, or sec_tens >5) are unreachable. No recovery logic is required beyond reset.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Add or clear pulse at edge N → digits and ready updated after edge N.
- Entering COUNT at edge N, with the prescaler at 0 → first decrement at edge N+TICKS_PER_SEC.
- finish is high for exactly one cycle.
  - The controller samples it on the following edge.
  - If the door opens in that same cycle, the pulse is lost by design; the time is already 00:00.
- ready falls on the same edge finish rises.
- ready is 0 while finish is 1.

## Structure
- Shared package `microwave_pkg`:
  - `bcd_t` (logic [3:0]).
  - `timer_state_t` enum {IDLE, SET, COUNT, EXPIRED}.
  - Constants MAX_MIN_BCD = 8'h99 and MAX_SEC_BCD = 8'h59.
- Sub-module `microwave_prescaler`, parameterised by TICKS_PER_SEC:
  - Counter width $clog2(TICKS_PER_SEC).
  - Inputs: clk, nrst, en, clr.
  - Output: sec_tick, a combinational wrap strobe.
- BCD add, saturate and decrement are combinational functions in `microwave_pkg`.

## Test plan
Unless stated otherwise, TICKS_PER_SEC = 4.

1. Reset then two add_10s pulses → digits 0,0,2,0; ready 1; state SET; finish 0.
2. Set 0:02, hold run high → 1 s at cycle 4, 0:00 at cycle 8. finish high exactly one cycle on that edge; ready falls on the same edge; IDLE one cycle later.
3. Set 1:00, run 4 cycles → 0:59 (borrow). Drop run for 10 cycles → digits hold. Raise run → 0:58 exactly 4 cycles after resume.
4. From 99:30, pulse add_min, then add_10s ×5 → saturates at 99:59. add_min and add_10s together from 0:00 → 1:10.
5. While counting at 0:03, pulse clear → 00:00, IDLE, no finish pulse ever. Separately, assert nrst low mid-count → 00:00, finish 0.
6. add_min pulse during COUNT is ignored. run high in IDLE for 20 cycles → digits stay 00:00, finish never asserts.
